// File: rtl/gpu_apb_cmd_queue.sv
// APB3 slave that buffers GPU command words in a first-word-fall-through FIFO.
// A full FIFO stalls the APB write for up to MAX_WAIT cycles before dropping it and flagging an error.
module gpu_apb_cmd_queue #(
    parameter int          DEPTH       = 8,
    parameter int          OPCODE_W    = 4,
    parameter int          MAX_WAIT    = 16,
    parameter logic [31:0] CMD_ADDR    = 32'h0,
    parameter logic [31:0] STATUS_ADDR = 32'h4
) (
    input  logic                     clk,
    input  logic                     n_rst,
    input  logic [31:0]              pAddr_i,
    input  logic [31:0]              pDataWrite_i,
    input  logic                     pSel_i,
    input  logic                     pEnable_i,
    input  logic                     pWrite_i,
    output logic                     pReady_o,
    output logic                     pSlvErr_o,
    output logic [31:0]              pDataRead_o,
    output logic                     command_o,
    input  logic                     cmd_ready_i,
    output logic [OPCODE_W-1:0]      opcode_o,
    output logic [31-OPCODE_W:0]     parameters_o,
    output logic [$clog2(DEPTH):0]   fifo_count_o
);

    localparam int PTR_W   = $clog2(DEPTH);
    localparam int CNT_W   = PTR_W + 1;
    localparam int WAIT_W  = $clog2(MAX_WAIT + 1);
    localparam int PARAM_W = 32 - OPCODE_W;

    localparam logic [CNT_W-1:0]  DEPTH_C    = CNT_W'(DEPTH);
    localparam logic [WAIT_W-1:0] MAX_WAIT_C = WAIT_W'(MAX_WAIT);

    localparam logic [0:0] IDLE   = 1'b0;
    localparam logic [0:0] ACCESS = 1'b1;

    logic [0:0]        state_reg, state_next;
    logic [PTR_W-1:0]  wr_ptr_reg, rd_ptr_reg;
    logic [CNT_W-1:0]  count_reg;
    logic [WAIT_W-1:0] wait_cnt_reg;
    logic              drop_err_reg;
    logic [31:0]       mem [DEPTH];

    logic        full, empty, transfer, cmd_hit, stat_hit, cmd_wr, stall;
    logic        push, pop, drop, clr;
    logic [7:0]  count8;
    logic [31:0] status_word, head;

    assign full     = (count_reg == DEPTH_C);
    assign empty    = (count_reg == '0);
    assign cmd_hit  = (pAddr_i == CMD_ADDR);
    assign stat_hit = (pAddr_i == STATUS_ADDR);
    assign transfer = (state_reg == ACCESS) && pSel_i && pEnable_i;
    assign cmd_wr   = transfer && pWrite_i && cmd_hit;

    // Fullness comes from the registered count, so a same-cycle pop frees the slot only next cycle.
    assign stall    = cmd_wr && full && (wait_cnt_reg != MAX_WAIT_C);

    assign pReady_o  = transfer && !stall;
    assign pSlvErr_o = pReady_o && !((cmd_wr && !full) || stat_hit);

    assign push = cmd_wr && !full;
    assign pop  = !empty && cmd_ready_i;
    assign drop = pReady_o && cmd_wr && full;
    assign clr  = pReady_o && pWrite_i && stat_hit && pDataWrite_i[2];

    always_comb begin
        count8 = '0;
        count8[CNT_W-1:0] = count_reg;
    end

    assign status_word = {16'b0, count8, 5'b0, drop_err_reg, full, empty};
    assign pDataRead_o = (pReady_o && !pWrite_i && stat_hit) ? status_word : 32'h0;

    assign head         = mem[rd_ptr_reg];
    assign command_o    = !empty;
    assign opcode_o     = empty ? '0 : head[31:PARAM_W];
    assign parameters_o = empty ? '0 : head[PARAM_W-1:0];
    assign fifo_count_o = count_reg;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (pSel_i && !pEnable_i) state_next = ACCESS;
            ACCESS:  if (!pSel_i || pReady_o)  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_reg    <= IDLE;
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            wait_cnt_reg <= '0;
            drop_err_reg <= 1'b0;
        end else begin
            state_reg <= state_next;

            if (pReady_o || !pSel_i)
                wait_cnt_reg <= '0;
            else if (stall)
                wait_cnt_reg <= wait_cnt_reg + 1'b1;

            if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;

            case ({push, pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase

            if (drop)
                drop_err_reg <= 1'b1;
            else if (clr)
                drop_err_reg <= 1'b0;
        end
    end

    // Storage needs no reset: occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_reg] <= pDataWrite_i;
    end

endmodule

// File: tb/tb_gpu_apb_cmd_queue.sv
// Self-checking bench for gpu_apb_cmd_queue: APB driver task, popped-command scoreboard,
// a register-access vector table and hand-written sequences for stall, pop-release and reset.
module tb_gpu_apb_cmd_queue;

    logic        clk = 1'b0;
    logic        n_rst;
    logic [31:0] paddr, pwdata;
    logic        psel, penable, pwrite;
    logic        pready, pslverr;
    logic [31:0] prdata;
    logic        command_o, cmd_ready;
    logic [3:0]  opcode;
    logic [27:0] params;
    logic [3:0]  count;

    int total = 0;
    int passed = 0;
    logic [31:0] sb [$];
    logic [31:0] exp_w;
    logic        idle_leak = 1'b0;

    always #5 clk = ~clk;

    gpu_apb_cmd_queue dut (
        .clk          (clk),
        .n_rst        (n_rst),
        .pAddr_i      (paddr),
        .pDataWrite_i (pwdata),
        .pSel_i       (psel),
        .pEnable_i    (penable),
        .pWrite_i     (pwrite),
        .pReady_o     (pready),
        .pSlvErr_o    (pslverr),
        .pDataRead_o  (prdata),
        .command_o    (command_o),
        .cmd_ready_i  (cmd_ready),
        .opcode_o     (opcode),
        .parameters_o (params),
        .fifo_count_o (count)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    // One APB transfer; returns read data, error and the number of access cycles.
    task automatic apb(input logic [31:0] addr, input logic [31:0] wdata, input logic wr,
                       output logic [31:0] rdata, output logic err, output int cycles);
        bit done = 0;
        cycles = 0; rdata = '0; err = 1'b0;
        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b0; paddr = addr; pwdata = wdata; pwrite = wr;
        @(posedge clk); #1;
        penable = 1'b1;
        while (!done && cycles < 40) begin
            @(negedge clk);
            cycles++;
            if (pready) begin
                done = 1; rdata = prdata; err = pslverr;
            end else if (pslverr || prdata != 0) begin
                idle_leak = 1'b1;
            end
            @(posedge clk); #1;
        end
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        if (!done) chk("apb_timeout", 32'd0, 32'd1);
    endtask

    task automatic push_cmd(input logic [31:0] data, input string name);
        logic [31:0] rd; logic er; int cyc;
        apb(32'h0, data, 1'b1, rd, er, cyc);
        chk({name, "_cycles"}, 32'(cyc), 32'd1);
        chk({name, "_err"}, 32'(er), 32'd0);
        sb.push_back(data);
    endtask

    // Scoreboard: every pop the DUT performs must match the oldest accepted command.
    always @(negedge clk) begin
        if (n_rst && command_o && cmd_ready) begin
            if (sb.size() == 0) chk("sb_underflow", 32'd1, 32'd0);
            else begin
                exp_w = sb.pop_front();
                chk("pop_data", {opcode, params}, exp_w);
            end
        end
    end

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        wr;
        logic        exp_err;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs [8];

    initial begin
        logic [31:0] rd;
        logic        er;
        int          cyc;
        logic [31:0] d;

        vecs[0] = '{32'h4, 32'h0, 1'b0, 1'b0, 32'h0806};
        vecs[1] = '{32'h0, 32'h0, 1'b0, 1'b1, 32'h0};
        vecs[2] = '{32'h8, 32'h0, 1'b0, 1'b1, 32'h0};
        vecs[3] = '{32'h8, 32'hFFFF_FFFF, 1'b1, 1'b1, 32'h0};
        vecs[4] = '{32'h4, 32'h0000_0003, 1'b1, 1'b0, 32'h0};
        vecs[5] = '{32'h4, 32'h0, 1'b0, 1'b0, 32'h0806};
        vecs[6] = '{32'h4, 32'h0000_0004, 1'b1, 1'b0, 32'h0};
        vecs[7] = '{32'h4, 32'h0, 1'b0, 1'b0, 32'h0802};

        n_rst = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        paddr = '0; pwdata = '0; cmd_ready = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_pready", 32'(pready), 32'd0);
        chk("rst_pslverr", 32'(pslverr), 32'd0);
        chk("rst_prdata", prdata, 32'd0);
        chk("rst_command", 32'(command_o), 32'd0);
        chk("rst_head", {opcode, params}, 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        n_rst = 1'b1;

        // 1: single write, visible the next cycle
        push_cmd(32'h3ABC_DEF1, "t1");
        chk("t1_command", 32'(command_o), 32'd1);
        chk("t1_opcode", 32'(opcode), 32'h3);
        chk("t1_params", 32'(params), 32'hABC_DEF1);
        chk("t1_count", 32'(count), 32'd1);
        cmd_ready = 1'b1;
        @(posedge clk); #1;
        cmd_ready = 1'b0;
        chk("t1_count_after_pop", 32'(count), 32'd0);
        chk("t1_head_empty", {opcode, params}, 32'd0);

        // 2: fill, then a ninth write stalls MAX_WAIT cycles and is dropped
        for (int i = 0; i < 8; i++) push_cmd($urandom, $sformatf("t2_w%0d", i));
        chk("t2_count_full", 32'(count), 32'd8);
        apb(32'h0, 32'hDEAD_BEEF, 1'b1, rd, er, cyc);
        chk("t2_drop_cycles", 32'(cyc), 32'd17);
        chk("t2_drop_err", 32'(er), 32'd1);
        chk("t2_count_after_drop", 32'(count), 32'd8);
        chk("t2_idle_outputs", 32'(idle_leak), 32'd0);

        // 5: register map vectors, including drop_err clear
        for (int i = 0; i < 8; i++) begin
            apb(vecs[i].addr, vecs[i].wdata, vecs[i].wr, rd, er, cyc);
            chk($sformatf("vec%0d_cycles", i), 32'(cyc), 32'd1);
            chk($sformatf("vec%0d_err", i), 32'(er), 32'(vecs[i].exp_err));
            if (!vecs[i].wr) chk($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
        end
        chk("t5_count", 32'(count), 32'd8);

        // 3: a pop during a stalled write releases it one cycle later
        d = $urandom;
        fork
            apb(32'h0, d, 1'b1, rd, er, cyc);
            begin
                repeat (4) @(posedge clk);
                #1 cmd_ready = 1'b1;
                @(posedge clk);
                #1 cmd_ready = 1'b0;
            end
        join
        chk("t3_cycles", 32'(cyc), 32'd4);
        chk("t3_err", 32'(er), 32'd0);
        chk("t3_count", 32'(count), 32'd8);
        sb.push_back(d);
        chk("t3_head", {opcode, params}, sb[0]);

        // 4: simultaneous push and pop at count 4
        cmd_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1 cmd_ready = 1'b0;
        chk("t4_count_start", 32'(count), 32'd4);
        for (int i = 0; i < 20; i++) begin
            d = $urandom;
            fork
                apb(32'h0, d, 1'b1, rd, er, cyc);
                begin
                    repeat (2) @(posedge clk);
                    #1 cmd_ready = 1'b1;
                    @(posedge clk);
                    #1 cmd_ready = 1'b0;
                end
            join
            sb.push_back(d);
            chk($sformatf("t4_count_%0d", i), 32'(count), 32'd4);
        end
        cmd_ready = 1'b1;
        for (int i = 0; i < 20 && command_o; i++) begin
            @(posedge clk); #1;
        end
        cmd_ready = 1'b0;
        chk("t4_drained_count", 32'(count), 32'd0);
        chk("t4_sb_empty", 32'(sb.size()), 32'd0);

        // 6: asynchronous reset in the middle of a stalled write
        for (int i = 0; i < 8; i++) push_cmd($urandom, $sformatf("t6_w%0d", i));
        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b0; paddr = 32'h0; pwdata = 32'h1234_5678; pwrite = 1'b1;
        @(posedge clk); #1;
        penable = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("t6_stalled", 32'(pready), 32'd0);
        #2 n_rst = 1'b0;
        #1;
        sb.delete();
        chk("t6_rst_pready", 32'(pready), 32'd0);
        chk("t6_rst_pslverr", 32'(pslverr), 32'd0);
        chk("t6_rst_prdata", prdata, 32'd0);
        chk("t6_rst_command", 32'(command_o), 32'd0);
        chk("t6_rst_head", {opcode, params}, 32'd0);
        chk("t6_rst_count", 32'(count), 32'd0);
        @(posedge clk); #1;
        n_rst = 1'b1;
        @(negedge clk);
        chk("t6_no_ready_after_rst", 32'(pready), 32'd0);
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        push_cmd(32'h9876_5432, "t6_after");
        chk("t6_count", 32'(count), 32'd1);
        chk("t6_head", {opcode, params}, 32'h9876_5432);
        cmd_ready = 1'b1;
        @(posedge clk); #1;
        cmd_ready = 1'b0;
        chk("t6_final_count", 32'(count), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
